triple_sample_voter: RTL and testbench
======================================

Name: triple_sample_voter

Overview:
- Serial-to-parallel front end for the 2-of-3 pair/triple detection stage.
- Accepts one bit per handshake and packs three consecutive bits into a group.
- Emits the group's majority value (1 when at least two of the three bits are 1) on a valid/ready output.
- Keeps a saturating count of groups that voted 1. Used to filter noisy single-bit streams before downstream logic.

Parameters:
- CNT_W, 8, width of the ones_count statistics counter (legal range 1..16).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_val  input  1  in_bit is valid this cycle.
- in_rdy  output  1  block can accept a bit this cycle.
- in_bit  input  1  serial data bit.
- out_val  output  1  out_bit holds a completed group's vote.
- out_rdy  input  1  consumer accepts the vote this cycle.
- out_bit  output  1  majority vote of the last completed group.
- ones_count  output  CNT_W  number of consumed groups whose vote was 1; saturating.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n. On a clk edge with rst_n=0:
  - state=COLLECT, idx=0, window=3'b000
  - out_val=0, out_bit=0, ones_count=0
  - in_rdy reads 1 in the first cycle after reset is released.
- Reset mid-operation: discards any partially collected group and any pending unconsumed vote. ones_count is cleared.
- State COLLECT:
  - in_rdy=1, out_val=0.
  - Input handshake: in_val && in_rdy.
  - On each handshake: window[idx] <= in_bit; idx increments. The first bit of a group lands in window[0].
  - When the handshake occurs with idx==2: next state is FULL, idx <= 0, out_bit <= maj(window[0], window[1], in_bit).
  - in_val=0 holds all state.
- State FULL:
  - in_rdy=0, out_val=1. out_bit is stable until consumed.
  - Output handshake: out_val && out_rdy.
  - On output handshake: next state is COLLECT, window <= 0. If out_bit==1, ones_count increments.
  - out_rdy=0 holds FULL indefinitely; input bits offered meanwhile are not accepted.
- Latency and throughput:
  - The third bit is accepted in cycle N; out_val=1 in cycle N+1.
  - With out_rdy tied to 1, the output handshake completes in cycle N+1 and in_rdy=1 in cycle N+2.
  - Peak rate is 4 cycles per group.
- ones_count saturates at 2^CNT_W-1 and never wraps. A vote-1 group consumed at saturation leaves the count unchanged.
- out_bit retains its last value in COLLECT; consumers qualify it with out_val.
- Every output is a register output or a decode of state. No combinational path from inputs to outputs.
- in_bit is a don't-care when in_val=0. in_rdy does not depend on in_val.

Optional Feature:
- Macro: TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN.
- When defined:
  - Adds output out_unan (1 bit). It is registered together with out_bit and is 1 when all three group bits are equal.
  - Reset value 0; valid only while out_val=1.
  - Adds output unan_count (CNT_W, saturating), which increments on each output handshake with out_unan=1. Reset value 0.
- When not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then in_val=1 with bits 1,0,1 and out_rdy=1 → out_val=1 one cycle after the third bit, out_bit=1, ones_count=1 after the handshake.
- Groups 0,0,1 and 1,1,1 and 0,0,0 → votes 0,1,0; ones_count=1 at the end; with the macro, out_unan = 0,1,1 and unan_count=2.
- Backpressure: complete a group, hold out_rdy=0 for 5 cycles while in_val=1 → in_rdy=0 and out_bit stable throughout. Release out_rdy → exactly one output handshake, then in_rdy=1.
- Gapped input: in_val toggles 1,0,0,1,0,1 with bits 1,x,x,1,x,0 → exactly one vote, out_bit=1; the idle cycles do not advance idx.
- Reset mid-group: send bits 1,1, assert rst_n=0 for one cycle, then send 0,0,0 → single vote out_bit=0, ones_count=0.
- Saturation with CNT_W=2: five consecutive groups of 1,1,0 → ones_count progresses 1,2,3,3,3.

Source files
------------

// File: rtl/triple_sample_voter.sv
// triple_sample_voter: packs three consecutive handshaked bits into a group,
// presents the 2-of-3 majority vote on a valid/ready output and keeps a
// saturating count of consumed groups that voted 1.
// Optional feature macro: TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN adds out_unan and
// unan_count (all three group bits equal, and its saturating count).
module triple_sample_voter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic             in_bit,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             out_bit,
    output logic [CNT_W-1:0] ones_count
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
    ,
    output logic             out_unan,
    output logic [CNT_W-1:0] unan_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       idx_q;
    // Only the first two bits of a group are stored; the third bit is
    // consumed directly into the vote on the cycle it arrives.
    logic [1:0]       window_q;
    logic             out_bit_q;
    logic [CNT_W-1:0] ones_count_q;
    logic             vote_d;
    logic             ones_sat;
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
    logic             out_unan_q;
    logic [CNT_W-1:0] unan_count_q;
    logic             unan_d;
    logic             unan_sat;
`endif

    // Vote and saturation decodes for the completing group / counters.
    always_comb begin
        vote_d   = (window_q[0] & window_q[1]) |
                   (window_q[0] & in_bit)      |
                   (window_q[1] & in_bit);
        ones_sat = &ones_count_q;
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
        unan_d   = (window_q[0] == window_q[1]) && (window_q[1] == in_bit);
        unan_sat = &unan_count_q;
`endif
    end

    // Collect/present state machine with registered vote and statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            idx_q        <= '0;
            window_q     <= '0;
            out_bit_q    <= 1'b0;
            ones_count_q <= '0;
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
            out_unan_q   <= 1'b0;
            unan_count_q <= '0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    if (in_val) begin
                        if (idx_q == 2'd2) begin
                            idx_q      <= '0;
                            out_bit_q  <= vote_d;
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
                            out_unan_q <= unan_d;
`endif
                            state_q    <= FULL;
                        end else begin
                            window_q[idx_q[0]] <= in_bit;
                            idx_q              <= idx_q + 2'd1;
                        end
                    end
                end
                FULL: begin
                    if (out_rdy) begin
                        state_q  <= COLLECT;
                        window_q <= '0;
                        if (out_bit_q && !ones_sat) begin
                            ones_count_q <= ones_count_q + CNT_ONE;
                        end
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
                        if (out_unan_q && !unan_sat) begin
                            unan_count_q <= unan_count_q + CNT_ONE;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign in_rdy     = (state_q == COLLECT);
    assign out_val    = (state_q == FULL);
    assign out_bit    = out_bit_q;
    assign ones_count = ones_count_q;
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
    assign out_unan   = out_unan_q;
    assign unan_count = unan_count_q;
`endif

endmodule

// File: tb/tb_triple_sample_voter.sv
// Directed testbench for triple_sample_voter: a default-width instance and a
// CNT_W=2 instance share the same stimulus; the narrow one covers saturation.
module tb_triple_sample_voter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_val = 1'b0;
    logic       in_bit = 1'b0;
    logic       out_rdy = 1'b0;

    logic       in_rdy, out_val, out_bit;
    logic [7:0] ones_count;
    logic       in_rdy2, out_val2, out_bit2;
    logic [1:0] ones_count2;
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
    logic       out_unan, out_unan2;
    logic [7:0] unan_count;
    logic [1:0] unan_count2;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    triple_sample_voter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy),
        .in_bit(in_bit), .out_val(out_val), .out_rdy(out_rdy),
        .out_bit(out_bit), .ones_count(ones_count)
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
        , .out_unan(out_unan), .unan_count(unan_count)
`endif
    );

    triple_sample_voter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy2),
        .in_bit(in_bit), .out_val(out_val2), .out_rdy(out_rdy),
        .out_bit(out_bit2), .ones_count(ones_count2)
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
        , .out_unan(out_unan2), .unan_count(unan_count2)
`endif
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Offer one bit and hold it until accepted (bounded).
    task automatic push(input logic b);
        int unsigned n;
        n = 0;
        while (!in_rdy && n < 20) begin
            tick();
            n++;
        end
        if (!in_rdy) check("push_timeout", 0, 1);
        in_val = 1'b1;
        in_bit = b;
        tick();
        in_val = 1'b0;
    endtask

    // Consume one vote (bounded wait on out_val).
    task automatic pop(output logic v, output logic u);
        int unsigned n;
        n = 0;
        u = 1'b0;
        while (!out_val && n < 20) begin
            tick();
            n++;
        end
        if (!out_val) check("pop_timeout", 0, 1);
        v = out_bit;
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
        u = out_unan;
`endif
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
    endtask

    initial begin
        logic        v, u;
        logic [2:0]  grp [3];
        logic        exp_vote [3];
        logic        exp_unan [3];
        logic        gv [6];
        logic        gb [6];
        int unsigned hs;
        logic [1:0]  sat_exp [5];

        // ---- Test 1: reset values and first group 1,0,1 ----
        rst_n = 1'b0;
        tick();
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_val", out_val, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_ones", ones_count, 0);
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
        check("rst_unan", out_unan, 0);
        check("rst_unan_cnt", unan_count, 0);
`endif
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        in_val  = 1'b1;
        in_bit  = 1'b1; tick();
        in_bit  = 1'b0; tick();
        check("t1_no_early_val", out_val, 0);
        in_bit  = 1'b1; tick();
        check("t1_out_val", out_val, 1);
        check("t1_out_bit", out_bit, 1);
        check("t1_in_rdy_full", in_rdy, 0);
        check("t1_ones_before", ones_count, 0);
        in_bit = 1'b0;
        tick();
        in_val = 1'b0;
        check("t1_out_val_done", out_val, 0);
        check("t1_in_rdy_again", in_rdy, 1);
        check("t1_ones", ones_count, 1);

        // ---- Test 2: groups 001, 111, 000 ----
        do_reset();
        grp[0] = 3'b001; exp_vote[0] = 1'b0; exp_unan[0] = 1'b0;
        grp[1] = 3'b111; exp_vote[1] = 1'b1; exp_unan[1] = 1'b1;
        grp[2] = 3'b000; exp_vote[2] = 1'b0; exp_unan[2] = 1'b1;
        for (int g = 0; g < 3; g++) begin
            // first bit sent is grp[g][2], written as read left to right
            push(grp[g][2]);
            push(grp[g][1]);
            push(grp[g][0]);
            pop(v, u);
            check($sformatf("t2_vote%0d", g), v, exp_vote[g]);
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
            check($sformatf("t2_unan%0d", g), u, exp_unan[g]);
`endif
        end
        check("t2_ones", ones_count, 1);
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
        check("t2_unan_cnt", unan_count, 2);
`endif

        // ---- Test 3: backpressure ----
        do_reset();
        push(1'b1); push(1'b1); push(1'b0);
        check("t3_out_val", out_val, 1);
        in_val = 1'b1;
        in_bit = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("t3_in_rdy_c%0d", c), in_rdy, 0);
            check($sformatf("t3_out_bit_c%0d", c), out_bit, 1);
            check($sformatf("t3_out_val_c%0d", c), out_val, 1);
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        hs = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_val && out_rdy) hs++;
            tick();
        end
        out_rdy = 1'b0;
        check("t3_handshakes", hs, 1);
        check("t3_in_rdy_after", in_rdy, 1);
        check("t3_ones", ones_count, 1);

        // ---- Test 4: gapped input 1,-,-,1,-,0 ----
        do_reset();
        gv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        gb = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 6; c++) begin
            in_val = gv[c];
            in_bit = gb[c];
            tick();
            if (c < 5) check($sformatf("t4_no_val_c%0d", c), out_val, 0);
        end
        in_val = 1'b0;
        check("t4_out_val", out_val, 1);
        check("t4_out_bit", out_bit, 1);
        out_rdy = 1'b1;
        hs = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_val && out_rdy) hs++;
            tick();
        end
        out_rdy = 1'b0;
        check("t4_votes", hs, 1);
        check("t4_ones", ones_count, 1);

        // ---- Test 5: reset mid-group ----
        do_reset();
        push(1'b1); push(1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_in_rdy", in_rdy, 1);
        push(1'b0); push(1'b0);
        check("t5_no_early_val", out_val, 0);
        push(1'b0);
        pop(v, u);
        check("t5_vote", v, 0);
        check("t5_ones", ones_count, 0);
        tick(); tick();
        check("t5_single_vote", out_val, 0);

        // ---- Test 6: saturation on the CNT_W=2 instance ----
        do_reset();
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int g = 0; g < 5; g++) begin
            push(1'b1); push(1'b1); push(1'b0);
            pop(v, u);
            check($sformatf("t6_vote%0d", g), v, 1);
            check($sformatf("t6_sat_cnt%0d", g), ones_count2, sat_exp[g]);
            check($sformatf("t6_wide_cnt%0d", g), ones_count, g + 1);
        end
`ifdef TRIPLE_SAMPLE_VOTER_UNANIMOUS_EN
        check("t6_unan_cnt", unan_count2, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
